iq_age_select: RTL and testbench
================================

// Module: iq_age_select
// PURPOSE
//  Oldest-first select arbiter for the instruction queue. Tracks relative age of IQ entries in an age
//  matrix and grants one issue per cycle to the oldest entry whose ready bit is set.
//  Sits between the wakeup logic (ready vector) and the issue port / payload-RAM read address; the
//  issued id is returned to the IQ freelist.
// PARAMETERS
//  IQ_DEPTH   `IqDepth        number of IQ entries (power of two, >=2)
//  IQ         $clog2(IQ_DEPTH) id width (constant, do not override)
// PORTS
//  clk          in   1         clock
//  reset_       in   1         asynchronous active-low reset
//  flush_       in   1         active-low synchronous flush (pipeline squash)
//  alloc_e_     in   1         active-low: entry alloc_id allocated this cycle
//  alloc_id     in   IQ        id from IQ freelist
//  ready        in   IQ_DEPTH  per-entry: operands ready and target unit not busy (from wakeup)
//  issue_stall  in   1         active-high: suppress issue this cycle
//  issue_e_     out  1         active-low: issue_id granted
//  issue_id     out  IQ        granted entry (payload RAM raddr, freelist wd)
//  valid        out  IQ_DEPTH  occupied-entry vector
//  empty        out  1         no valid entries
// BEHAVIOUR
//  - State: valid[IQ_DEPTH]; age[i][j] (1 = entry i older than j), diagonal unused, i!=j only.
//  - Reset / flush_=0: valid=0, age=0; issue_e_=1, issue_id=0, empty=1. Flush overrides alloc/issue same cycle.
//  - Alloc (alloc_e_=0): next valid[alloc_id]=1; age[alloc_id][*]=0; age[*][alloc_id]=valid[*]
//    (current, pre-update valid with issued bit cleared) -> newcomer younger than all survivors.
//  - Request: req[i] = valid[i] & ready[i] & ~issue_stall. Newly allocated entry is not requestable in its alloc cycle.
//  - Grant: i wins iff req[i] & ~|(req[j] & age[j][i]) over j!=i; exactly one winner when |req.
//    Ties impossible by construction; any-one-hot violation is an assertion failure.
//  - Issue: combinational, same cycle as req (zero latency); issue_e_=0 iff |req; issue_id=winner,
//    else issue_id=0. Next-cycle valid[issue_id]=0; age rows/cols of issued entry become don't-care.
//  - Simultaneous alloc and issue: both applied; alloc_id==issue_id in the same cycle is illegal (freelist
//    cannot return an id before it is written back) -> assertion.
//  - Alloc to already-valid entry -> assertion; RTL overwrites (entry becomes youngest).
//  - Full: all valid, no alloc expected (freelist busy). Empty: issue_e_=1 regardless of ready.
//  - Wrap-around: none; age is relative, no counter to overflow.
//  - ready bits of invalid entries ignored.
// CONFIGURATION
//  IQ_SELECT_OUTREG_EN defined: grant registered; issue_e_/issue_id valid one cycle after req;
//   the granted entry is masked from req in the grant cycle (pending bit) to prevent a double grant;
//   valid clears when the registered issue fires; flush_ also kills the pending registered grant.
//  Undefined: combinational grant as above (default).
// STRUCTURE
//  - Shared package/header (issue.svh): IqId_t typedef, IqDepth already in cpu_config.svh.
//  - One sub-module: iq_age_matrix (age/valid storage, alloc/clear update, per-entry older-req mask);
//    top holds request masking, grant encode, optional output register.
// TESTING
//  1 Reset: reset_=0 mid-run with 3 valid -> issue_e_=1, issue_id=0, valid=0, empty=1.
//  2 Order: alloc 5,2,7 on consecutive cycles, then ready=all -> issues 5,2,7 on 3 consecutive cycles.
//  3 Ready skip: valid 5(old),2; ready[5]=0,ready[2]=1 -> issue 2; ready[5]=1 next -> issue 5.
//  4 Alloc+issue same cycle: valid {3}, ready[3]=1, alloc 4 -> issue 3; next cycle 4 issues, valid={4}->{}.
//  5 Flush: 4 valid, flush_=0 with alloc_e_=0 -> next cycle valid=0, no issue, allocation dropped.
//  6 Stall/full: fill all IQ_DEPTH, issue_stall=1 -> no issue; release -> oldest (first alloc) issues first.

Source files
------------

// File: rtl/iq_age_select_pkg.sv
// Shared constants for the instruction-queue oldest-first select arbiter.
package iq_age_select_pkg;

  localparam int IQ_DEPTH_DEF = 8;

endpackage

// File: rtl/iq_age_matrix.sv
// Age/valid storage for the IQ select: alloc/clear update and per-entry
// "some older entry is requesting" mask.
module iq_age_matrix
  import iq_age_select_pkg::*;
#(
  parameter  int IQ_DEPTH = IQ_DEPTH_DEF,
  localparam int IQ       = $clog2(IQ_DEPTH)
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic                flush_,
  input  logic                alloc_en,
  input  logic [IQ-1:0]       alloc_id,
  input  logic                clr_en,
  input  logic [IQ-1:0]       clr_id,
  input  logic [IQ_DEPTH-1:0] req,
  output logic [IQ_DEPTH-1:0] valid,
  output logic [IQ_DEPTH-1:0] older_req
);

  // age[i][j] = 1 means entry i is older than entry j
  logic [IQ_DEPTH-1:0] age [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] clr_mask;
  logic [IQ_DEPTH-1:0] alloc_mask;
  logic [IQ_DEPTH-1:0] survivors;

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    clr_mask   = '0;
    alloc_mask = '0;
    if (clr_en)   clr_mask[clr_id]     = 1'b1;
    if (alloc_en) alloc_mask[alloc_id] = 1'b1;
  end

  assign survivors = valid & ~clr_mask;

  // NOTE: the age matrix is a small flop array, not a RAM, so it is cleared by reset like any register.
  // NOTE: state is written with non-blocking assignments so every bit samples pre-edge values.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      valid <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) age[i] <= '0;
    end else if (!flush_) begin
      valid <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) age[i] <= '0;
    end else begin
      valid <= survivors | alloc_mask;
      if (alloc_en) begin
        // Newcomer is younger than every entry that survives this cycle.
        for (int i = 0; i < IQ_DEPTH; i++) begin
          for (int j = 0; j < IQ_DEPTH; j++) begin
            if (i == int'(alloc_id))      age[i][j] <= 1'b0;
            else if (j == int'(alloc_id)) age[i][j] <= survivors[i];
          end
        end
      end
    end
  end

  always_comb begin
    older_req = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      for (int j = 0; j < IQ_DEPTH; j++) begin
        if (j != i) older_req[i] = older_req[i] | (req[j] & age[j][i]);
      end
    end
  end

endmodule

// File: rtl/iq_age_select.sv
// Oldest-first issue select for the instruction queue. Define IQ_SELECT_OUTREG_EN
// to register the grant (issue one cycle after request); default is combinational.
module iq_age_select
  import iq_age_select_pkg::*;
#(
  parameter  int IQ_DEPTH = IQ_DEPTH_DEF,
  localparam int IQ       = $clog2(IQ_DEPTH)
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic                flush_,
  input  logic                alloc_e_,
  input  logic [IQ-1:0]       alloc_id,
  input  logic [IQ_DEPTH-1:0] ready,
  input  logic                issue_stall,
  output logic                issue_e_,
  output logic [IQ-1:0]       issue_id,
  output logic [IQ_DEPTH-1:0] valid,
  output logic                empty
);

  logic [IQ_DEPTH-1:0] req;
  logic [IQ_DEPTH-1:0] older_req;
  logic [IQ_DEPTH-1:0] win;
  logic [IQ-1:0]       win_id;
  logic                clr_en;
  logic [IQ-1:0]       clr_id;
  logic [IQ_DEPTH-1:0] pend_mask;

  iq_age_matrix #(.IQ_DEPTH(IQ_DEPTH)) u_matrix (
    .clk       (clk),
    .reset_    (reset_),
    .flush_    (flush_),
    .alloc_en  (~alloc_e_),
    .alloc_id  (alloc_id),
    .clr_en    (clr_en),
    .clr_id    (clr_id),
    .req       (req),
    .valid     (valid),
    .older_req (older_req)
  );

  assign req = valid & ready & ~pend_mask & {IQ_DEPTH{~issue_stall & flush_}};
  assign win = req & ~older_req;

  always_comb begin
    win_id = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (win[i]) win_id = win_id | IQ'(i);
    end
  end

`ifdef IQ_SELECT_OUTREG_EN
  logic          pend_v;
  logic [IQ-1:0] pend_id;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      pend_v  <= 1'b0;
      pend_id <= '0;
    end else begin
      pend_v  <= flush_ & (|req);
      pend_id <= win_id;
    end
  end

  // The registered winner is still valid while it fires; keep it out of req.
  always_comb begin
    pend_mask = '0;
    if (pend_v) pend_mask[pend_id] = 1'b1;
  end

  assign issue_e_ = ~(pend_v & flush_);
  assign issue_id = (pend_v & flush_) ? pend_id : '0;
  assign clr_en   = pend_v;
  assign clr_id   = pend_id;
`else
  assign pend_mask = '0;
  assign issue_e_  = ~(|req);
  assign issue_id  = win_id;
  assign clr_en    = |req;
  assign clr_id    = win_id;
`endif

  assign empty = ~(|valid);

  a_one_winner : assert property (@(posedge clk) disable iff (!reset_) $onehot0(win))
    else $error("iq_age_select: more than one grant winner");

  a_alloc_free : assert property (@(posedge clk) disable iff (!reset_)
                                  (!alloc_e_ && flush_) |-> !valid[alloc_id])
    else $error("iq_age_select: alloc to an already-valid entry");

  a_alloc_not_issued : assert property (@(posedge clk) disable iff (!reset_)
                                        (!alloc_e_ && flush_ && clr_en) |-> (alloc_id != clr_id))
    else $error("iq_age_select: alloc_id equals the id being issued");

endmodule

// File: tb/tb_iq_age_select.sv
// Directed bench for iq_age_select: an allocation-order queue model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_iq_age_select;

  localparam int N  = 8;
  localparam int IQ = $clog2(N);

  logic          clk;
  logic          reset_;
  logic          flush_;
  logic          alloc_e_;
  logic [IQ-1:0] alloc_id;
  logic [N-1:0]  ready;
  logic          issue_stall;
  logic          issue_e_;
  logic [IQ-1:0] issue_id;
  logic [N-1:0]  valid;
  logic          empty;

  int n_cmp = 0;
  int n_bad = 0;

  iq_age_select #(.IQ_DEPTH(N)) dut (
    .clk         (clk),
    .reset_      (reset_),
    .flush_      (flush_),
    .alloc_e_    (alloc_e_),
    .alloc_id    (alloc_id),
    .ready       (ready),
    .issue_stall (issue_stall),
    .issue_e_    (issue_e_),
    .issue_id    (issue_id),
    .valid       (valid),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: live ids kept oldest-first; the oldest ready one issues.
  int           age_q[$];
  logic [N-1:0] m_valid;
  logic         m_iss;
  int           m_id;
  int           m_idx;

  always @(negedge clk) begin
    if (!reset_) age_q.delete();
    m_valid = '0;
    foreach (age_q[k]) m_valid[age_q[k]] = 1'b1;
    m_iss = 1'b0;
    m_id  = 0;
    m_idx = -1;
    if (flush_ && !issue_stall) begin
      for (int k = 0; k < age_q.size(); k++) begin
        if (ready[age_q[k]]) begin
          m_iss = 1'b1;
          m_id  = age_q[k];
          m_idx = k;
          break;
        end
      end
    end
    check("model_issue_e_", 32'(issue_e_), 32'(!m_iss));
    check("model_issue_id", 32'(issue_id), 32'(m_id));
    check("model_valid",    32'(valid),    32'(m_valid));
    check("model_empty",    32'(empty),    32'(m_valid == '0));
    if (reset_) begin
      if (!flush_) age_q.delete();
      else begin
        if (m_iss) age_q.delete(m_idx);
        if (!alloc_e_) begin
          for (int k = age_q.size() - 1; k >= 0; k--)
            if (age_q[k] == int'(alloc_id)) age_q.delete(k);
          age_q.push_back(int'(alloc_id));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input int id);
    alloc_e_ = 1'b0;
    alloc_id = IQ'(id);
  endtask

  initial begin
    reset_ = 1'b0; flush_ = 1'b1; alloc_e_ = 1'b1; alloc_id = '0;
    ready = '0; issue_stall = 1'b0;
    cyc(); cyc();
    #2;
    check("por_issue_e_", 32'(issue_e_), 32'd1);
    check("por_valid",    32'(valid),    32'h0);
    check("por_empty",    32'(empty),    32'd1);
    cyc(); reset_ = 1'b1;

    // Reset mid-run with three valid entries
    cyc(); alloc(1);
    cyc(); alloc(2);
    cyc(); alloc(3);
    cyc(); alloc_e_ = 1'b1;
    #2 check("rst_pre_valid", 32'(valid), 32'h0E);
    cyc(); reset_ = 1'b0;
    #2;
    check("rst_issue_e_", 32'(issue_e_), 32'd1);
    check("rst_issue_id", 32'(issue_id), 32'd0);
    check("rst_valid",    32'(valid),    32'h0);
    check("rst_empty",    32'(empty),    32'd1);
    cyc(); reset_ = 1'b1;

    // Allocation order 5,2,7 issues in the same order
    cyc(); alloc(5);
    cyc(); alloc(2);
    cyc(); alloc(7);
    cyc(); alloc_e_ = 1'b1; ready = '1;
    #2;
    check("order_valid",  32'(valid),    32'hA4);
    check("order_e0",     32'(issue_e_), 32'd0);
    check("order_id0",    32'(issue_id), 32'd5);
    cyc(); #2 check("order_id1", 32'(issue_id), 32'd2);
    cyc(); #2 check("order_id2", 32'(issue_id), 32'd7);
    cyc(); #2;
    check("order_done_e", 32'(issue_e_), 32'd1);
    check("order_empty",  32'(empty),    32'd1);

    // Older entry not ready is skipped
    cyc(); ready = '0; alloc(5);
    cyc(); alloc(2);
    cyc(); alloc_e_ = 1'b1; ready = 8'h04;
    #2 check("skip_id_young", 32'(issue_id), 32'd2);
    cyc(); ready = 8'h20;
    #2 check("skip_id_old", 32'(issue_id), 32'd5);
    cyc(); ready = '0;
    #2 check("skip_empty", 32'(empty), 32'd1);

    // Alloc and issue in the same cycle; newcomer not requestable yet
    cyc(); alloc(3);
    cyc(); alloc(4); ready = 8'h18;
    #2 check("ai_id3", 32'(issue_id), 32'd3);
    cyc(); alloc_e_ = 1'b1;
    #2;
    check("ai_valid4", 32'(valid),    32'h10);
    check("ai_id4",    32'(issue_id), 32'd4);
    cyc(); #2;
    check("ai_valid0", 32'(valid),    32'h0);
    check("ai_e_idle", 32'(issue_e_), 32'd1);

    // Flush overrides alloc and issue
    cyc(); ready = '0; alloc(0);
    cyc(); alloc(1);
    cyc(); alloc(2);
    cyc(); alloc(3);
    cyc(); alloc(6); flush_ = 1'b0; ready = '1;
    #2 check("flush_no_issue", 32'(issue_e_), 32'd1);
    cyc(); flush_ = 1'b1; alloc_e_ = 1'b1; ready = '0;
    #2;
    check("flush_valid", 32'(valid), 32'h0);
    check("flush_empty", 32'(empty), 32'd1);

    // Fill every entry under stall, then release
    issue_stall = 1'b1; ready = '1;
    cyc(); alloc(6);
    cyc(); alloc(1);
    cyc(); alloc(4);
    cyc(); alloc(0);
    cyc(); alloc(7);
    cyc(); alloc(3);
    cyc(); alloc(5);
    cyc(); alloc(2);
    cyc(); alloc_e_ = 1'b1;
    #2;
    check("full_valid",   32'(valid),    32'hFF);
    check("full_stalled", 32'(issue_e_), 32'd1);
    cyc(); issue_stall = 1'b0;
    #2 check("full_first", 32'(issue_id), 32'd6);
    cyc(); #2 check("full_second", 32'(issue_id), 32'd1);
    repeat (6) cyc();
    cyc(); #2 check("full_drained", 32'(empty), 32'd1);

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
